wb_mem_tester: RTL and testbench

//  Synthesizable pipelined Wishbone master that stress-tests a memory slave, e.g. the sdram controller.

---
 rtl/wb_mem_tester_pkg.sv | 40 ++++
 rtl/wb_mem_tester_pattern.sv | 58 +++++
 rtl/wb_mem_tester.sv | 229 ++++++++++++++++++++++
 tb/tb_wb_mem_tester.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mem_tester_pkg.sv
// Shared definitions for the Wishbone memory tester.
//   mode_e  : data pattern selection (matches the 2-bit mode_i encoding)
//   state_e : top-level FSM states
//   lfsr_taps() : Galois tap mask (right-shifting form) for a given data width
package wb_mem_tester_pkg;

  typedef enum logic [1:0] {
    MODE_INCR = 2'd0,  // seed + i
    MODE_ADDR = 2'd1,  // byte address of the word
    MODE_LFSR = 2'd2,  // Galois LFSR seeded with seed
    MODE_WALK = 2'd3   // walking one
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_WDRAIN = 3'd2,
    ST_READ   = 3'd3,
    ST_RDRAIN = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  localparam logic [63:0] LFSR_TAPS_16 = 64'h0000_0000_0000_B400;
  localparam logic [63:0] LFSR_TAPS_32 = 64'h0000_0000_8020_0003;
  localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

  // Tap mask applied when the bit shifted out is 1: next = (s >> 1) ^ taps.
  function automatic logic [63:0] lfsr_taps(input int width);
    case (width)
      16:      return LFSR_TAPS_16;
      24:      return 64'h0000_0000_00E1_0000;
      32:      return LFSR_TAPS_32;
      40:      return 64'h0000_00A0_0014_0000;
      48:      return 64'h0000_C000_0018_0000;
      56:      return 64'h00C0_0006_0000_0000;
      default: return LFSR_TAPS_64;
    endcase
  endfunction

endpackage

// File: rtl/wb_mem_tester_pattern.sv
// Word pattern generator used on both the issue and the check side.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : restart the sequence at word 0 for mode_i/seed_i
//   advance_i    : step to the next word (ignored while load_i is high)
//   mode_i       : pattern selection (mode_e encoding)
//   seed_i       : seed for incr and LFSR modes
//   pattern_o    : current word, registered
// Every pattern is kept as a running value so each step is a single
// add/shift/rotate rather than a multiply by the word index.
module wb_mem_tester_pattern
  import wb_mem_tester_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] seed_i,
  output logic [DATA_W-1:0] pattern_o
);

  localparam logic [63:0]       TAPS64 = lfsr_taps(DATA_W);
  localparam logic [DATA_W-1:0] TAPS   = TAPS64[DATA_W-1:0];
  localparam logic [DATA_W-1:0] STEP   = DATA_W'(DATA_W / 8);
  // Address pattern is the byte address zero-extended or truncated to DATA_W.
  localparam logic [DATA_W-1:0] BASE_D = DATA_W'(BASE_ADDR);

  logic [DATA_W-1:0] pat_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pat_q <= '0;
    end else if (load_i) begin
      case (mode_e'(mode_i))
        MODE_INCR: pat_q <= seed_i;
        MODE_ADDR: pat_q <= BASE_D;
        MODE_LFSR: pat_q <= (seed_i == '0) ? '1 : seed_i;  // all-zero state would lock up
        default:   pat_q <= DATA_W'(1);
      endcase
    end else if (advance_i) begin
      case (mode_e'(mode_i))
        MODE_INCR: pat_q <= pat_q + DATA_W'(1);
        MODE_ADDR: pat_q <= pat_q + STEP;
        MODE_LFSR: pat_q <= (pat_q >> 1) ^ (pat_q[0] ? TAPS : '0);
        default:   pat_q <= {pat_q[DATA_W-2:0], pat_q[DATA_W-1]};
      endcase
    end
  end

  assign pattern_o = pat_q;

endmodule

// File: rtl/wb_mem_tester.sv
// Pipelined Wishbone master that writes a pattern over a memory region,
// reads it back and checks every word.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   start_i               : start pulse, honoured only in IDLE/DONE
//   mode_i, seed_i, len_i : pattern mode, seed and word count, latched at start
//   wb_*                  : pipelined Wishbone master port
//   busy_o, done_o        : test running / test finished (level)
//   pass_o                : valid with done_o, 1 when no mismatches
//   err_count_o           : saturating mismatch count
//   first_err_addr_o/data_o : address and read data of the first mismatch
module wb_mem_tester
  import wb_mem_tester_pkg::*;
#(
  parameter int                ADDR_W          = 32,
  parameter int                DATA_W          = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR       = '0,
  parameter int                MAX_OUTSTANDING = 4,
  parameter int                LEN_W           = 24
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [1:0]          mode_i,
  input  logic [DATA_W-1:0]   seed_i,
  input  logic [LEN_W-1:0]    len_i,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic [ADDR_W-1:0]   wb_addr_o,
  output logic [DATA_W-1:0]   wb_data_o,
  input  logic [DATA_W-1:0]   wb_data_i,
  input  logic                wb_stall_i,
  input  logic                wb_ack_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [15:0]         err_count_o,
  output logic [ADDR_W-1:0]   first_err_addr_o,
  output logic [DATA_W-1:0]   first_err_data_o
);

  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(DATA_W / 8);
  localparam logic [3:0]        MAX_OUT = 4'(MAX_OUTSTANDING);

  state_e             state_q;
  logic [1:0]         mode_q;
  logic [DATA_W-1:0]  seed_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   issued_q;
  logic [3:0]         out_q;
  logic [ADDR_W-1:0]  chk_addr_q;
  logic               first_seen_q;

  logic               idle_like;
  logic               start_go;
  logic               start_nil;
  logic               accept;
  logic               ack_ok;
  logic               rd_ack;
  logic [3:0]         out_next;
  logic [LEN_W-1:0]   issued_next;
  logic               last_issue;
  logic               more_ok;
  logic               reload;
  logic               mismatch;
  logic [1:0]         pat_mode;
  logic [DATA_W-1:0]  pat_seed;
  logic [DATA_W-1:0]  iss_pat;
  logic [DATA_W-1:0]  chk_pat;

  assign idle_like   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_go    = start_i && idle_like && (len_i != '0);
  assign start_nil   = start_i && idle_like && (len_i == '0);
  assign accept      = wb_stb_o && !wb_stall_i;
  // A stray ack with nothing outstanding is dropped here so it can neither
  // underflow the counter nor advance the checker.
  assign ack_ok      = wb_ack_i && (out_q != '0);
  // The write phase fully drains before READ, so every ack seen in
  // READ/RDRAIN belongs to a read.
  assign rd_ack      = ack_ok && ((state_q == ST_READ) || (state_q == ST_RDRAIN));
  assign out_next    = out_q + {3'b000, accept} - {3'b000, ack_ok};
  assign issued_next = issued_q + LEN_W'(accept);
  assign last_issue  = (issued_next == len_q);
  // Strobe is registered, so it is decided from the post-edge counts.
  assign more_ok     = !last_issue && (out_next < MAX_OUT);
  assign reload      = (state_q == ST_WDRAIN) && (out_q == '0);
  assign mismatch    = rd_ack && (wb_data_i != chk_pat);

  // Generators load from the live inputs at start and from the latched
  // copies when the issue side rewinds for the read phase.
  assign pat_mode    = idle_like ? mode_i : mode_q;
  assign pat_seed    = idle_like ? seed_i : seed_q;

  wb_mem_tester_pattern #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_issue_pat (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (start_go || reload),
    .advance_i (accept),
    .mode_i    (pat_mode),
    .seed_i    (pat_seed),
    .pattern_o (iss_pat)
  );

  wb_mem_tester_pattern #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_check_pat (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (start_go),
    .advance_i (rd_ack),
    .mode_i    (pat_mode),
    .seed_i    (pat_seed),
    .pattern_o (chk_pat)
  );

  assign wb_sel_o  = wb_stb_o ? '1 : '0;
  assign wb_data_o = wb_we_o ? iss_pat : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      mode_q           <= '0;
      seed_q           <= '0;
      len_q            <= '0;
      issued_q         <= '0;
      out_q            <= '0;
      chk_addr_q       <= BASE_ADDR;
      first_seen_q     <= 1'b0;
      wb_cyc_o         <= 1'b0;
      wb_stb_o         <= 1'b0;
      wb_we_o          <= 1'b0;
      wb_addr_o        <= BASE_ADDR;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      pass_o           <= 1'b0;
      err_count_o      <= '0;
      first_err_addr_o <= '0;
      first_err_data_o <= '0;
    end else begin
      out_q <= out_next;

      if (rd_ack) chk_addr_q <= chk_addr_q + STEP;

      if (mismatch) begin
        if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
        if (!first_seen_q) begin
          first_seen_q     <= 1'b1;
          first_err_addr_o <= chk_addr_q;
          first_err_data_o <= wb_data_i;
        end
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_nil) begin
            state_q          <= ST_DONE;
            done_o           <= 1'b1;
            pass_o           <= 1'b1;
            err_count_o      <= '0;
            first_seen_q     <= 1'b0;
            first_err_addr_o <= '0;
            first_err_data_o <= '0;
          end else if (start_go) begin
            state_q          <= ST_WRITE;
            mode_q           <= mode_i;
            seed_q           <= seed_i;
            len_q            <= len_i;
            issued_q         <= '0;
            chk_addr_q       <= BASE_ADDR;
            wb_cyc_o         <= 1'b1;
            wb_stb_o         <= 1'b1;
            wb_we_o          <= 1'b1;
            wb_addr_o        <= BASE_ADDR;
            busy_o           <= 1'b1;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            err_count_o      <= '0;
            first_seen_q     <= 1'b0;
            first_err_addr_o <= '0;
            first_err_data_o <= '0;
          end
        end

        ST_WRITE, ST_READ: begin
          if ((state_q == ST_READ) && !wb_cyc_o) begin
            // End of the one-cycle bus gap between the two phases.
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
          end else begin
            issued_q <= issued_next;
            if (accept) wb_addr_o <= wb_addr_o + STEP;
            wb_stb_o <= more_ok;
            if (last_issue) state_q <= (state_q == ST_WRITE) ? ST_WDRAIN : ST_RDRAIN;
          end
        end

        ST_WDRAIN: begin
          if (out_q == '0) begin
            state_q   <= ST_READ;
            wb_cyc_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_addr_o <= BASE_ADDR;
            issued_q  <= '0;
          end
        end

        ST_RDRAIN: begin
          if (out_q == '0) begin
            state_q  <= ST_DONE;
            wb_cyc_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            pass_o   <= (err_count_o == '0);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_tester.sv
// Directed bench for wb_mem_tester. Two DUTs share the stimulus inputs:
// instance 0 has BASE_ADDR=0, instance 1 has BASE_ADDR=32'hFFFFFFF8.
// Each has a pipelined RAM model with optional alternate-cycle stall,
// fixed ack latency and a single-address read bit flip, plus a monitor
// that counts accepts, tracks outstanding requests and logs writes.
module tb_wb_mem_tester;

  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  start;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic [23:0] len;

  int          stall_alt;
  int          lat;
  logic        flip_en;
  logic [31:0] flip_addr;
  logic        mon_clr;

  logic [1:0]  done_v;
  logic [1:0]  busy_v;

  int n_chk = 0;
  int n_err = 0;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic        cyc, stb, we, stall, ack;
    logic [3:0]  sel;
    logic [31:0] addr, wdata, rdata;
    logic        busy, done, pass;
    logic [15:0] err_cnt;
    logic [31:0] fe_addr, fe_data;

    wb_mem_tester #(
      .ADDR_W          (32),
      .DATA_W          (32),
      .BASE_ADDR       ((g == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8),
      .MAX_OUTSTANDING (MAX_OUT),
      .LEN_W           (24)
    ) u_dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .start_i          (start[g]),
      .mode_i           (mode),
      .seed_i           (seed),
      .len_i            (len),
      .wb_cyc_o         (cyc),
      .wb_stb_o         (stb),
      .wb_we_o          (we),
      .wb_sel_o         (sel),
      .wb_addr_o        (addr),
      .wb_data_o        (wdata),
      .wb_data_i        (rdata),
      .wb_stall_i       (stall),
      .wb_ack_i         (ack),
      .busy_o           (busy),
      .done_o           (done),
      .pass_o           (pass),
      .err_count_o      (err_cnt),
      .first_err_addr_o (fe_addr),
      .first_err_data_o (fe_data)
    );

    assign done_v[g] = done;
    assign busy_v[g] = busy;

    // RAM model
    logic [31:0] mem [0:1023];
    logic [7:0]  dv;
    logic [31:0] dd [0:7];
    wire         acc    = cyc && stb && !stall;
    wire  [31:0] rd_val = mem[addr[11:2]] ^
                          {31'b0, (flip_en && !we && (addr == flip_addr))};

    always @(posedge clk) begin
      if (rst) begin
        dv    <= '0;
        ack   <= 1'b0;
        stall <= 1'b0;
        rdata <= '0;
      end else begin
        stall <= (stall_alt != 0) ? !stall : 1'b0;
        if (acc && we) mem[addr[11:2]] <= wdata;
        dv <= (dv >> 1) | (acc ? (8'b1 << (lat - 1)) : 8'b0);
        for (int k = 0; k < 7; k++) dd[k] <= dd[k+1];
        if (acc) dd[lat-1] <= rd_val;
        ack   <= dv[0];
        rdata <= dd[0];
      end
    end

    // Bus monitor
    int          acc_cnt, outst, max_out, stall_viol;
    logic        cyc_seen;
    logic        hold_v;
    logic [31:0] hold_addr, hold_data;
    logic [31:0] wa [0:7];
    logic [31:0] wd [0:7];

    always @(posedge clk) begin
      if (rst || mon_clr) begin
        acc_cnt    <= 0;
        outst      <= 0;
        max_out    <= 0;
        stall_viol <= 0;
        cyc_seen   <= 1'b0;
        hold_v     <= 1'b0;
      end else begin
        if (acc) acc_cnt <= acc_cnt + 1;
        outst <= outst + (acc ? 1 : 0) - (ack ? 1 : 0);
        if (outst > max_out) max_out <= outst;
        cyc_seen <= cyc_seen | cyc;
        if (hold_v && !(stb && addr == hold_addr && wdata == hold_data))
          stall_viol <= stall_viol + 1;
        hold_v    <= stb && stall;
        hold_addr <= addr;
        hold_data <= wdata;
        if (acc && we && acc_cnt < 8) begin
          wa[acc_cnt[2:0]] <= addr;
          wd[acc_cnt[2:0]] <= wdata;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input int s);
    start[s] = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
  endtask

  task automatic clear_monitors();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic wait_done(input int s, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (done_v[s]) break;
      @(negedge clk);
    end
    check(tag, done_v[s], 1);
  endtask

  initial begin
    rst = 1'b1; start = '0; mode = 2'd0; seed = '0; len = '0;
    stall_alt = 0; lat = 1; flip_en = 1'b0; flip_addr = '0; mon_clr = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cyc",   g_inst[0].cyc, 0);
    check("rst_stb",   g_inst[0].stb, 0);
    check("rst_busy",  g_inst[0].busy, 0);
    check("rst_done",  g_inst[0].done, 0);
    check("rst_pass",  g_inst[0].pass, 0);
    check("rst_err",   g_inst[0].err_cnt, 0);
    check("rst_addr0", g_inst[0].addr, 32'h0);
    check("rst_addr1", g_inst[1].addr, 32'hFFFF_FFF8);
    rst = 1'b0;
    @(negedge clk);

    // len=0: done one cycle after start, bus untouched
    clear_monitors();
    len = 24'd0;
    pulse_start(0);
    check("nil_done", g_inst[0].done, 1);
    check("nil_pass", g_inst[0].pass, 1);
    repeat (4) @(negedge clk);
    check("nil_nocyc", g_inst[0].cyc_seen, 0);

    // Incrementing pattern, no stall
    clear_monitors();
    mode = 2'd0; seed = 32'hddeeffaa; len = 24'd4;
    pulse_start(0);
    check("t1_cyc",  g_inst[0].cyc, 1);
    check("t1_we",   g_inst[0].we, 1);
    check("t1_sel",  g_inst[0].sel, 4'hF);
    check("t1_busy", g_inst[0].busy, 1);
    check("t1_done", g_inst[0].done, 0);
    wait_done(0, 200, "t1_finish");
    for (int i = 0; i < 4; i++) begin
      check("t1_waddr", g_inst[0].wa[i], 32'(4 * i));
      check("t1_wdata", g_inst[0].wd[i], 32'hddeeffaa + 32'(i));
    end
    check("t1_pass", g_inst[0].pass, 1);
    check("t1_err",  g_inst[0].err_cnt, 0);
    check("t1_acc",  g_inst[0].acc_cnt, 8);

    // Same run, word @8 corrupted on read
    clear_monitors();
    flip_en = 1'b1; flip_addr = 32'h8;
    pulse_start(0);
    wait_done(0, 200, "t2_finish");
    check("t2_err",   g_inst[0].err_cnt, 1);
    check("t2_faddr", g_inst[0].fe_addr, 32'h8);
    check("t2_fdata", g_inst[0].fe_data, 32'hddeeffad);
    check("t2_pass",  g_inst[0].pass, 0);
    flip_en = 1'b0;

    // LFSR, long run, stall every other cycle, ack latency 3
    clear_monitors();
    mode = 2'd2; seed = 32'h1; len = 24'd512; stall_alt = 1; lat = 3;
    pulse_start(0);
    check("t3_err_cleared", g_inst[0].err_cnt, 0);
    wait_done(0, 20000, "t3_finish");
    check("t3_pass",   g_inst[0].pass, 1);
    check("t3_err",    g_inst[0].err_cnt, 0);
    check("t3_maxout", (g_inst[0].max_out <= MAX_OUT), 1);
    check("t3_stable", g_inst[0].stall_viol, 0);
    check("t3_wd0",    g_inst[0].wd[0], 32'h0000_0001);
    check("t3_wd1",    g_inst[0].wd[1], 32'h8020_0003);
    check("t3_wd2",    g_inst[0].wd[2], 32'hC030_0002);
    check("t3_acc",    g_inst[0].acc_cnt, 1024);
    stall_alt = 0; lat = 1;
    @(negedge clk);

    // Reset during the write phase at word 10 of 64
    clear_monitors();
    mode = 2'd0; seed = 32'h0; len = 24'd64;
    pulse_start(0);
    for (int i = 0; i < 200; i++) begin
      if (g_inst[0].acc_cnt >= 10) break;
      @(negedge clk);
    end
    check("t5_reached10", g_inst[0].acc_cnt, 10);
    rst = 1'b1;
    @(negedge clk);
    check("t5_cyc",  g_inst[0].cyc, 0);
    check("t5_stb",  g_inst[0].stb, 0);
    check("t5_busy", g_inst[0].busy, 0);
    check("t5_err",  g_inst[0].err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    pulse_start(0);
    wait_done(0, 500, "t5_restart_finish");
    check("t5_pass", g_inst[0].pass, 1);

    // Address pattern wrapping past the top of the address space
    clear_monitors();
    mode = 2'd1; seed = 32'h0; len = 24'd4;
    pulse_start(1);
    check("t6_busy", busy_v[1], 1);
    // Start pulse while busy, with different settings, must be ignored
    mode = 2'd0; len = 24'd9;
    pulse_start(1);
    mode = 2'd1; len = 24'd4;
    wait_done(1, 200, "t6_finish");
    check("t6_a0", g_inst[1].wa[0], 32'hFFFF_FFF8);
    check("t6_a1", g_inst[1].wa[1], 32'hFFFF_FFFC);
    check("t6_a2", g_inst[1].wa[2], 32'h0000_0000);
    check("t6_a3", g_inst[1].wa[3], 32'h0000_0004);
    check("t6_d0", g_inst[1].wd[0], 32'hFFFF_FFF8);
    check("t6_d3", g_inst[1].wd[3], 32'h0000_0004);
    check("t6_pass", g_inst[1].pass, 1);
    repeat (5) @(negedge clk);
    check("t6_acc",  g_inst[1].acc_cnt, 8);
    check("t6_hold", g_inst[1].done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
